// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly, selectable W8^k twiddle; 2-cycle latency, elastic valid/ready, stalls hold outputs.
// Define BFLY_SCALE_EN to halve the stage-2 results (floor) instead of wrapping; out_ovf is then 0.
module butterfly_r2_pipe #(
  parameter int N  = 3,
  parameter int CW = 2**N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      twiddle_sel,
  input  logic [2**N-1:0] in_1_r,
  input  logic [2**N-1:0] in_1_i,
  input  logic [2**N-1:0] in_2_r,
  input  logic [2**N-1:0] in_2_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] out_1_r,
  output logic [2**N-1:0] out_1_i,
  output logic [2**N-1:0] out_2_r,
  output logic [2**N-1:0] out_2_i,
  output logic            out_ovf
);
  localparam int W = 2**N;
  localparam int C = $rtoi((2.0 ** CW) * 0.70710678118654752 + 0.5);
  localparam logic signed [CW:0] C_S = (CW+1)'(C);

  // Multiply by 1/sqrt(2): floor of (x*C) >> CW, then wrap to W bits.
  function automatic logic [W-1:0] scale(input logic signed [W:0] x);
    logic signed [W+CW+1:0] p;
    p = (W+CW+2)'(x) * (W+CW+2)'(C_S);
    return W'(p >>> CW);
  endfunction

  function automatic logic [W:0] sx(input logic [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic ovf(input logic [W:0] v);
    return v[W] ^ v[W-1];
  endfunction

  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [W-1:0]    s1_1r_q, s1_1r_d, s1_1i_q, s1_1i_d;
  logic [W-1:0]    s1_tr_q, s1_tr_d, s1_ti_q, s1_ti_d;
  logic [W-1:0]    out_1_r_q, out_1_r_d, out_1_i_q, out_1_i_d;
  logic [W-1:0]    out_2_r_q, out_2_r_d, out_2_i_q, out_2_i_d;
  logic            out_ovf_q, out_ovf_d;
  logic            adv1, adv2;
  logic signed [W:0] r9, m9;
  logic [W-1:0]    tw_r, tw_i;
  logic [W:0]      a_r, a_i, b_r, b_i;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  always_comb begin
    r9   = $signed(sx(in_2_r));
    m9   = $signed(sx(in_2_i));
    tw_r = in_2_r;
    tw_i = in_2_i;
    case (twiddle_sel)
      2'd1: begin
        tw_r = scale(r9 + m9);
        tw_i = scale(m9 - r9);
      end
      2'd2: begin
        tw_r = in_2_i;
        tw_i = -in_2_r;
      end
      2'd3: begin
        tw_r = scale(m9 - r9);
        tw_i = scale(-(r9 + m9));
      end
      default: ;
    endcase
  end

  always_comb begin
    a_r = sx(s1_1r_q) + sx(s1_tr_q);
    a_i = sx(s1_1i_q) + sx(s1_ti_q);
    b_r = sx(s1_1r_q) - sx(s1_tr_q);
    b_i = sx(s1_1i_q) - sx(s1_ti_q);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_1r_d    = s1_1r_q;
    s1_1i_d    = s1_1i_q;
    s1_tr_d    = s1_tr_q;
    s1_ti_d    = s1_ti_q;
    s2_valid_d = s2_valid_q;
    out_1_r_d  = out_1_r_q;
    out_1_i_d  = out_1_i_q;
    out_2_r_d  = out_2_r_q;
    out_2_i_d  = out_2_i_q;
    out_ovf_d  = out_ovf_q;
    if (adv1) s1_valid_d = in_valid;
    if (adv1 && in_valid) begin
      s1_1r_d = in_1_r;
      s1_1i_d = in_1_i;
      s1_tr_d = tw_r;
      s1_ti_d = tw_i;
    end
    if (adv2) s2_valid_d = s1_valid_q;
    // Output registers only change when a beat actually moves into stage 2.
    if (adv2 && s1_valid_q) begin
`ifdef BFLY_SCALE_EN
      out_1_r_d = a_r[W:1];
      out_1_i_d = a_i[W:1];
      out_2_r_d = b_r[W:1];
      out_2_i_d = b_i[W:1];
      out_ovf_d = 1'b0;
`else
      out_1_r_d = a_r[W-1:0];
      out_1_i_d = a_i[W-1:0];
      out_2_r_d = b_r[W-1:0];
      out_2_i_d = b_i[W-1:0];
      out_ovf_d = ovf(a_r) | ovf(a_i) | ovf(b_r) | ovf(b_i);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_1r_q    <= '0;
      s1_1i_q    <= '0;
      s1_tr_q    <= '0;
      s1_ti_q    <= '0;
      out_1_r_q  <= '0;
      out_1_i_q  <= '0;
      out_2_r_q  <= '0;
      out_2_i_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_1r_q    <= s1_1r_d;
      s1_1i_q    <= s1_1i_d;
      s1_tr_q    <= s1_tr_d;
      s1_ti_q    <= s1_ti_d;
      out_1_r_q  <= out_1_r_d;
      out_1_i_q  <= out_1_i_d;
      out_2_r_q  <= out_2_r_d;
      out_2_i_q  <= out_2_i_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_1_r   = out_1_r_q;
  assign out_1_i   = out_1_i_q;
  assign out_2_r   = out_2_r_q;
  assign out_2_i   = out_2_i_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: doc/butterfly_r2_pipe.md
Name: butterfly_r2_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the 8-point FFT datapath.
- Applies one of four selectable twiddles W8^k (k=0..3) to the second operand: 1, (1-i)/√2, -i, (-1-i)/√2.
- Returns the sum and difference with the first operand.
- Two register stages with valid/ready handshake. Intended to replace the fixed-twiddle combinational butterflies inside a streaming FFT stage.

Parameters:
- N, 3, data width exponent; every real/imag component is W = 2**N bits, signed two's complement.
- CW, 2**N, fractional bits of the 1/√2 constant; C = round(2**CW / √2) (181 for CW=8).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- twiddle_sel  in  2  k, selects W8^k; sampled with the beat
- in_1_r, in_1_i  in  W  first operand
- in_2_r, in_2_i  in  W  second operand (twiddled)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_1_r, out_1_i  out  W  in_1 + W8^k·in_2
- out_2_r, out_2_i  out  W  in_1 - W8^k·in_2
- out_ovf  out  1  any of the four output sums overflowed W bits (this beat)

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): s1_valid=0, s2_valid=0, and all out_* data and out_ovf = 0. Takes priority over every other event, including a mid-stream flush; in-flight beats are discarded. in_ready=1 the cycle after reset.
- Stage 1 register holds in_1 and the twiddled value t, where r=in_2_r, m=in_2_i.
  - k=0: t=(r, m)
  - k=1: t=(s(r+m), s(m-r))
  - k=2: t=(m, -r)
  - k=3: t=(s(m-r), s(-(r+m)))
- s(x):
  - x is formed at W+1 bits.
  - Compute (x·C) >>> CW, an arithmetic shift (floor), then truncate to W bits.
  - Negation wraps: -(-2^(W-1)) = -2^(W-1).
- Stage 2 register:
  - Sums formed at W+1 bits: a = in_1 + t, b = in_1 - t.
  - Outputs are the low W bits (wrap).
  - out_ovf = 1 if any of the four W+1-bit results is outside the signed W range.
- Handshake, standard elastic pipeline:
  - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2.
  - in_ready = adv1, purely combinational from state and out_ready.
  - Input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 beat/cycle.
- While out_valid & !out_ready, out_* and out_ovf hold stable. Maximum 2 beats in flight; order is preserved; no loss or duplication.
- Simultaneous events:
  - Accepting a beat while emitting one in the same cycle is legal at full rate.
  - twiddle_sel is ignored when no transfer occurs.

Optional Feature:
- Macro BFLY_SCALE_EN.
- Defined: stage 2 outputs are the W+1-bit sums arithmetically shifted right by 1 (floor), giving the per-stage 1/2 scaling. Overflow cannot occur; out_ovf is tied to 0.
- Undefined: wrap behaviour and out_ovf as specified above.

Test Plan:
- N=3, k=0, in1=(10,5), in2=(3,-2), out_ready=1 -> two cycles later out_valid=1, out1=(13,3), out2=(7,7), out_ovf=0.
- k=1, in1=(0,0), in2=(20,20) -> t=(28,0); out1=(28,0), out2=(-28,0). Also k=3, in1=(0,0), in2=(0,-1) -> t=(-1,0) (floor check), out1=(-1,0), out2=(1,0).
- k=2, in1=(1,1), in2=(5,7) -> t=(7,-5); out1=(8,-4), out2=(-6,6).
- k=0, in1=(100,0), in2=(100,0):
  - Without macro -> out1_r=-56 (wrap), out_ovf=1, out2=(0,0).
  - With BFLY_SCALE_EN -> out1_r=100, out2=(0,0), out_ovf=0.
- Backpressure:
  - Stimulus: stream beats A..D back-to-back with out_ready=0 for 3 cycles.
  - Response: in_ready drops once 2 beats are held; out data stable while stalled; A..D emerge in order exactly once after out_ready=1.
- Reset mid-stream:
  - Stimulus: assert rst one cycle with both stages valid.
  - Response: next cycle out_valid=0, outputs=0, in_ready=1; the first beat accepted afterwards appears 2 cycles later with correct values.
